// File: rtl/mux_pkg.sv
// Shared select encodings, FSM states and the round-robin pick used by the
// display-mux select scheduler.
package mux_pkg;

  localparam logic [1:0] SEL_DATA1 = 2'b00;
  localparam logic [1:0] SEL_DATA3 = 2'b01;
  localparam logic [1:0] SEL_DATA2 = 2'b10;
  localparam logic [1:0] SEL_NONE  = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DWELL = 1'b1
  } state_t;

  function automatic logic req_hit(input logic [2:0] req, input logic [1:0] idx);
    case (idx)
      SEL_DATA1: req_hit = req[0];
      SEL_DATA3: req_hit = req[1];
      SEL_DATA2: req_hit = req[2];
      default:   req_hit = 1'b0;
    endcase
  endfunction

  // First requesting index in order p+1, p+2, p (mod 3); SEL_NONE if none.
  function automatic logic [1:0] rr_next(input logic [2:0] req, input logic [1:0] p);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = (p >= 2'd2) ? 2'd0 : p + 2'd1;
    c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    if (req_hit(req, c1))      rr_next = c1;
    else if (req_hit(req, c2)) rr_next = c2;
    else if (req_hit(req, p))  rr_next = p;
    else                       rr_next = SEL_NONE;
  endfunction

endpackage

// File: rtl/mux_sel_scheduler_if.sv
// Control/select bundle between switches/buttons, the scheduler and the mux.
interface mux_sel_scheduler_if;
  import mux_pkg::*;

  logic       i_en;
  logic       i_mode;
  logic       i_next;
  logic [2:0] i_req;
  // o_valid qualifies o_sel (o_sel is 2'b11 whenever o_valid is 0); o_tick
  // marks the single cycle in which o_sel was (re)loaded. No back-pressure.
  logic [1:0] o_sel;
  logic       o_valid;
  logic       o_tick;
  state_t     dbg_state;

  modport master (
    output i_en, i_mode, i_next, i_req,
    input  o_sel, o_valid, o_tick, dbg_state
  );

  modport slave (
    input  i_en, i_mode, i_next, i_req,
    output o_sel, o_valid, o_tick, dbg_state
  );
endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level followed by a
// single-cycle rising-edge detector.
module sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= i_d;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign o_rise = s2_q & ~s3_q;

endmodule

// File: rtl/mux_sel_scheduler.sv
// Round-robin select scheduler for the 4-bit display mux: timed dwell in
// auto mode, button-driven advance in either mode, requesters may drop out.
module mux_sel_scheduler
  import mux_pkg::*;
#(
  parameter int DWELL  = 50000000,
  parameter int NB_CNT = 26
) (
  input logic                i_clk,
  input logic                i_rst_n,
  mux_sel_scheduler_if.slave bus
);

  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DWELL - 1);
  localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);

  state_t            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic              valid_q, valid_d;
  logic              tick_q, tick_d;
  logic [NB_CNT-1:0] cnt_q, cnt_d;
  logic [1:0]        ptr_q, ptr_d;
  logic              mode_q;
  logic              nxt;
  logic              load;
  logic [1:0]        load_val;

  sync_edge u_next_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (bus.i_next),
    .o_rise  (nxt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_NONE;
      valid_q <= 1'b0;
      tick_q  <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= SEL_DATA2;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      mode_q  <= bus.i_mode;
    end
  end

  // Advance priority in DWELL: all dropped > current dropped > button > timer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    load_val = sel_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.i_req != 3'b000) begin
          state_d  = ST_DWELL;
          load     = 1'b1;
          load_val = rr_next(bus.i_req, ptr_q);
        end
      end
      ST_DWELL: begin
        if (bus.i_req == 3'b000) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!req_hit(bus.i_req, sel_q) || nxt) begin
          load     = 1'b1;
          load_val = rr_next(bus.i_req, sel_q);
          cnt_d    = '0;
        end else if (!bus.i_mode && bus.i_en) begin
          if (cnt_q == CNT_LAST) begin
            load     = 1'b1;
            load_val = rr_next(bus.i_req, sel_q);
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.i_mode != mode_q) cnt_d = '0;
    ptr_d = load ? load_val : ptr_q;
  end

  always_comb begin
    tick_d  = load;
    valid_d = (state_d == ST_DWELL);
    if (state_d == ST_IDLE) sel_d = SEL_NONE;
    else if (load)          sel_d = load_val;
    else                    sel_d = sel_q;
  end

  assign bus.o_sel     = sel_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_tick    = tick_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// Bench for mux_sel_scheduler: directed scenarios with pinned values plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_mux_sel_scheduler;
  import mux_pkg::*;

  localparam int DWELL  = 4;
  localparam int NB_CNT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mux_sel_scheduler_if bus ();

  mux_sel_scheduler #(.DWELL(DWELL), .NB_CNT(NB_CNT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  // ---------------- behavioural model ----------------
  logic [4:0] exp_q[$];
  int   m_sel = 3;
  bit   m_valid = 0;
  bit   m_tick = 0;
  int   m_cnt = 0;
  int   m_ptr = 2;
  bit   m_mode_prev = 0;
  bit   in_hist[1:3] = '{0, 0, 0};

  function automatic int rr(input logic [2:0] req, input int p);
    for (int k = 1; k <= 3; k++)
      if (req[(p + k) % 3]) return (p + k) % 3;
    return 3;
  endfunction

  function automatic logic [4:0] pack_exp();
    logic [1:0] s;
    s = 2'(m_sel);
    return {m_valid, s, m_valid, m_tick};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sel = 3; m_valid = 0; m_tick = 0; m_cnt = 0; m_ptr = 2; m_mode_prev = 0;
      in_hist[1] = 0; in_hist[2] = 0; in_hist[3] = 0;
      exp_q.delete();
      exp_q.push_back(pack_exp());
    end else begin
      bit press;
      bit timer_due;
      // A button sample becomes an advance request three edges later.
      press = in_hist[2] && !in_hist[3];
      timer_due = !bus.i_mode && bus.i_en && (m_cnt == DWELL - 1);
      m_tick = 0;
      if (!m_valid) begin
        if (bus.i_req != 3'b000) begin
          m_sel = rr(bus.i_req, m_ptr); m_ptr = m_sel;
          m_valid = 1; m_tick = 1; m_cnt = 0;
        end
      end else if (bus.i_req == 3'b000) begin
        m_valid = 0; m_sel = 3; m_cnt = 0;
      end else if (!bus.i_req[m_sel] || press || timer_due) begin
        m_sel = rr(bus.i_req, m_sel); m_ptr = m_sel;
        m_tick = 1; m_cnt = 0;
      end else if (!bus.i_mode && bus.i_en) begin
        m_cnt = m_cnt + 1;
      end
      if (bus.i_mode != m_mode_prev) m_cnt = 0;
      m_mode_prev = bus.i_mode;
      in_hist[3] = in_hist[2]; in_hist[2] = in_hist[1]; in_hist[1] = bus.i_next;
      exp_q.push_back(pack_exp());
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [4:0] act;
    logic [4:0] exp_v;
    act = {bus.dbg_state == ST_DWELL, bus.o_sel, bus.o_valid, bus.o_tick};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL model_queue at %0t: got empty queue required one entry", $time);
    end else begin
      exp_v = exp_q.pop_front();
      if (act !== exp_v) begin
        errors++;
        $display("FAIL cycle_compare at %0t: got {st,sel,valid,tick}=%b required %b",
                 $time, act, exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0d required %0d", name, $time, act, exp_v);
    end
  endtask

  task automatic do_reset(input logic [2:0] req, input logic mode, input logic en);
    rst_n = 1'b0;
    bus.i_req = req; bus.i_mode = mode; bus.i_en = en; bus.i_next = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_bad;
    int n_tick;
    bus.i_req = 3'b111; bus.i_mode = 1'b0; bus.i_en = 1'b1; bus.i_next = 1'b0;

    // Reset with all requesters active, then auto rotation.
    cyc(); cyc(); cyc();
    check("reset_sel", {2'b00, bus.o_sel}, 4'd3);
    check("reset_valid", {3'b000, bus.o_valid}, 4'd0);
    check("reset_tick", {3'b000, bus.o_tick}, 4'd0);
    rst_n = 1'b1;
    cyc();
    check("first_grant_sel", {2'b00, bus.o_sel}, 4'd0);
    check("first_grant_valid", {3'b000, bus.o_valid}, 4'd1);
    check("first_grant_tick", {3'b000, bus.o_tick}, 4'd1);
    for (int k = 2; k <= 13; k++) begin
      cyc();
      if (k == 4)  check("auto_e4_sel", {2'b00, bus.o_sel}, 4'd0);
      if (k == 5)  check("auto_e5_sel", {2'b00, bus.o_sel}, 4'd1);
      if (k == 6)  check("auto_e6_tick", {3'b000, bus.o_tick}, 4'd0);
      if (k == 9)  check("auto_e9_sel", {2'b00, bus.o_sel}, 4'd2);
      if (k == 13) check("auto_e13_sel", {2'b00, bus.o_sel}, 4'd0);
    end
    cyc();
    rst_n = 1'b0;
    #1;
    check("async_reset_sel", {2'b00, bus.o_sel}, 4'd3);
    check("async_reset_valid", {3'b000, bus.o_valid}, 4'd0);

    // Skip of a non-requester, then a single requester.
    do_reset(3'b101, 1'b0, 1'b1);
    n_bad = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (bus.o_sel == 2'b01) n_bad++;
      if (k == 5) check("skip_e5_sel", {2'b00, bus.o_sel}, 4'd2);
      if (k == 9) check("skip_e9_sel", {2'b00, bus.o_sel}, 4'd0);
    end
    check("skip_never_01", 4'(n_bad), 4'd0);
    bus.i_req = 3'b010;
    n_bad = 0; n_tick = 0;
    for (int k = 13; k <= 24; k++) begin
      cyc();
      if (bus.o_sel != 2'b01) n_bad++;
      if (bus.o_tick) n_tick++;
    end
    check("single_sel_held", 4'(n_bad), 4'd0);
    check("single_tick_count", 4'(n_tick), 4'd3);

    // Requester drop mid-dwell, then all requests gone.
    do_reset(3'b111, 1'b0, 1'b1);
    repeat (6) cyc();
    check("drop_pre_sel", {2'b00, bus.o_sel}, 4'd1);
    bus.i_req = 3'b101;
    cyc();
    check("drop_sel", {2'b00, bus.o_sel}, 4'd2);
    check("drop_tick", {3'b000, bus.o_tick}, 4'd1);
    repeat (3) cyc();
    check("drop_hold_sel", {2'b00, bus.o_sel}, 4'd2);
    cyc();
    check("drop_after_sel", {2'b00, bus.o_sel}, 4'd0);
    bus.i_req = 3'b000;
    cyc();
    check("idle_sel", {2'b00, bus.o_sel}, 4'd3);
    check("idle_valid", {3'b000, bus.o_valid}, 4'd0);

    // Manual mode, button held high.
    do_reset(3'b111, 1'b1, 1'b1);
    repeat (3) cyc();
    check("man_start_sel", {2'b00, bus.o_sel}, 4'd0);
    bus.i_next = 1'b1;
    repeat (2) cyc();
    check("man_before_sel", {2'b00, bus.o_sel}, 4'd0);
    cyc();
    check("man_adv_sel", {2'b00, bus.o_sel}, 4'd1);
    check("man_adv_tick", {3'b000, bus.o_tick}, 4'd1);
    n_bad = 0; n_tick = 0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      if (bus.o_sel != 2'b01) n_bad++;
      if (bus.o_tick) n_tick++;
    end
    bus.i_next = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (bus.o_sel != 2'b01) n_bad++;
      if (bus.o_tick) n_tick++;
    end
    check("man_hold_sel", 4'(n_bad), 4'd0);
    check("man_hold_tick", 4'(n_tick), 4'd0);

    // Enable dropped in auto mode freezes the dwell.
    do_reset(3'b111, 1'b0, 1'b1);
    repeat (11) cyc();
    check("en_pre_sel", {2'b00, bus.o_sel}, 4'd2);
    bus.i_en = 1'b0;
    n_bad = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (bus.o_sel != 2'b10) n_bad++;
    end
    check("en_frozen_sel", 4'(n_bad), 4'd0);
    bus.i_en = 1'b1;
    cyc();
    check("en_resume1_sel", {2'b00, bus.o_sel}, 4'd2);
    cyc();
    check("en_resume2_sel", {2'b00, bus.o_sel}, 4'd0);
    check("en_resume2_tick", {3'b000, bus.o_tick}, 4'd1);

    // Randomized run checked by the per-cycle scoreboard.
    do_reset(3'($urandom_range(1, 7)), 1'b0, 1'b1);
    for (int k = 0; k < 3000; k++) begin
      cyc();
      if ($urandom_range(0, 5) == 0) bus.i_req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) bus.i_en = ~bus.i_en;
      if ($urandom_range(0, 39) == 0) bus.i_mode = ~bus.i_mode;
      if ($urandom_range(0, 4) == 0) bus.i_next = ~bus.i_next;
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1;
        check("rand_async_reset_sel", {2'b00, bus.o_sel}, 4'd3);
        cyc();
        rst_n = 1'b1;
      end
    end

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
